axi_llc_lock_box_table: RTL and testbench
=========================================

# axi_llc_lock_box_table

Exact-match successor to the bloom-filter lock box in the AXI LLC hit/miss detection path. It tracks locked cache lines (index plus one-hot way) in a small fully-associative table of per-line reference counters, so lookups never report a false positive. It accepts a parametrised number of unlock channels, each buffered in its own FIFO of configurable depth and merged by a round-robin arbiter. It backpressures lock requests when the table cannot hold them and flags protocol errors.

## Interface
- IndexWidth, 8, width of the set-index field.
- WayWidth, 8, width of the one-hot way field (equals set associativity).
- NumEntries, 8, lock-table entries; ≥ 2.
- CntWidth, 3, per-entry reference counter width; saturates at 2^CntWidth−1.
- NumUnlock, 2, number of unlock channels; ≥ 1.
- FifoDepth, 2, entries per unlock FIFO; ≥ 1.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- lock_index_i  in  IndexWidth  lookup/lock index.
- lock_way_i  in  WayWidth  lookup/lock way.
- lock_req_i  in  1  increment the line's counter.
- lock_gnt_o  out  1  lock accepted this cycle.
- locked_o  out  1  line {lock_index_i, lock_way_i} currently held.
- unlock_index_i  in  NumUnlock×IndexWidth  per-channel unlock index.
- unlock_way_i  in  NumUnlock×WayWidth  per-channel unlock way.
- unlock_req_i  in  NumUnlock  per-channel unlock request.
- unlock_gnt_o  out  NumUnlock  per-channel FIFO not full.
- usage_o  out  $clog2(NumEntries+1)  number of valid entries.
- full_o  out  1  all entries valid.
- empty_o  out  1  no entry valid.
- error_o  out  1  sticky error flag.

## Operation
- Key = {index, way}. Entry state = valid, key, count.
- Lookup is combinational on current register state: locked_o = any valid entry whose key matches the lock inputs.
- lock_gnt_o = lock_req_i & (a matching entry exists with count < max, or no matching entry exists and a free entry exists).
- Granted lock on a hit increments count. Granted lock on a miss allocates the lowest-index free entry with count = 1.
- A lock request on a saturated entry is not granted and holds off; no error is raised.
- Unlock channel c pushes when unlock_req_i[c] & unlock_gnt_o[c]. The FIFO is not fall-through.
- The arbiter picks one non-empty FIFO per cycle, round-robin. Priority starts at channel 0 after reset and moves to the channel after the winner. The winning head is popped unconditionally.
- The popped key decrements its matching entry. A count of 1→0 clears valid.
- A popped key with no matching valid entry sets error_o; the table is unchanged.
- Granted lock and decrement on the same entry in the same cycle: count unchanged, entry stays valid.
- An entry freed by a decrement is not visible as free for allocation until the next cycle.
- Any bit of a way field other than exactly one set bit, on a lock or a pop, sets error_o and the operation is dropped.
- error_o is cleared only by reset.

## Timing
- Reset: all entries invalid, counters 0, FIFOs empty, arbiter pointer 0.
- Reset output values: lock_gnt_o = 0, locked_o = 0, unlock_gnt_o = all 1, usage_o = 0, full_o = 0, empty_o = 1, error_o = 0.
- Reset mid-operation discards all locks and buffered unlocks in the following cycle.
- lock_gnt_o and locked_o are combinational from the inputs and the current state.
- Lock effect is visible on locked_o, usage_o, full_o and empty_o one cycle after the grant.
- Unlock latency: push at cycle t; earliest pop at t+1; entry update visible at t+2.
- Each channel sustains one unlock per cycle when it is uncontended.
- unlock_gnt_o[c] depends on registered FIFO state only, with no combinational path from pop. A full FIFO does not accept a push in the same cycle it pops.
- Aggregate decrement throughput is one per cycle.

## Test plan
- Reset, then lock {0x12, 0x04}. Next cycle: locked_o = 1 for that key, locked_o = 0 for {0x12, 0x08}, usage_o = 1, empty_o = 0.
- Lock the same key 7 times with CntWidth = 3. The 8th lock gets lock_gnt_o = 0. Then 7 unlocks on channel 1 leave the entry invalid 2 cycles after the last push.
- Lock 8 distinct keys: full_o = 1. A 9th distinct key gets lock_gnt_o = 0. A 9th lock on an existing key gets lock_gnt_o = 1.
- With NumUnlock = 3, push one unlock per channel in the same cycle. The pops complete in order 0, 1, 2 over 3 consecutive cycles, and unlock_gnt_o stays 1 throughout.
- Entry at count 1 receives a lock and a decrement pop in the same cycle: count remains 1 and locked_o stays 1.
- Unlock a never-locked key: error_o = 1 two cycles after the push and stays 1 until rst_i. A lock with way 0x06 also sets error_o.

Source files
------------

// File: rtl/axi_llc_lock_box_table.sv
// Exact-match lock table for AXI LLC lines: per-line reference counters, lock
// lookup/grant, and per-channel unlock FIFOs merged by a round-robin arbiter.
module axi_llc_lock_box_table #(
  parameter int unsigned IndexWidth = 8,
  parameter int unsigned WayWidth   = 8,
  parameter int unsigned NumEntries = 8,
  parameter int unsigned CntWidth   = 3,
  parameter int unsigned NumUnlock  = 2,
  parameter int unsigned FifoDepth  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [IndexWidth-1:0]             lock_index_i,
  input  logic [WayWidth-1:0]               lock_way_i,
  input  logic                              lock_req_i,
  output logic                              lock_gnt_o,
  output logic                              locked_o,
  input  logic [NumUnlock*IndexWidth-1:0]   unlock_index_i,
  input  logic [NumUnlock*WayWidth-1:0]     unlock_way_i,
  input  logic [NumUnlock-1:0]              unlock_req_i,
  output logic [NumUnlock-1:0]              unlock_gnt_o,
  output logic [$clog2(NumEntries+1)-1:0]   usage_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              error_o
);

  localparam int unsigned KeyWidth = IndexWidth + WayWidth;
  localparam int unsigned EntW     = $clog2(NumEntries);
  localparam int unsigned UsageW   = $clog2(NumEntries + 1);
  localparam int unsigned PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned FcntW    = $clog2(FifoDepth + 1);
  localparam int unsigned ChW      = (NumUnlock > 1) ? $clog2(NumUnlock) : 1;

  logic [NumEntries-1:0] valid_q;
  logic [KeyWidth-1:0]   key_q [NumEntries];
  logic [CntWidth-1:0]   cnt_q [NumEntries];

  logic [KeyWidth-1:0]   fifo_mem [NumUnlock][FifoDepth];
  logic [PtrW-1:0]       rd_ptr [NumUnlock];
  logic [PtrW-1:0]       wr_ptr [NumUnlock];
  logic [FcntW-1:0]      fifo_cnt [NumUnlock];
  logic [ChW-1:0]        rr_ptr;

  logic [KeyWidth-1:0]   lock_key, pop_key;
  logic [KeyWidth-1:0]   push_key [NumUnlock];
  logic [NumUnlock-1:0]  push, pop, nonempty;
  logic [ChW-1:0]        win;
  logic                  pop_valid, pop_way_ok, lock_way_ok;
  logic [NumEntries-1:0] match_lock, match_pop;
  logic                  hit_lock, hit_sat, any_free, hit_pop, pop_do;
  logic [EntW-1:0]       free_idx;
  logic [UsageW-1:0]     usage;

  assign lock_key    = {lock_index_i, lock_way_i};
  assign lock_way_ok = $onehot(lock_way_i);

  // FIFO handshake derived from registered occupancy only
  always_comb begin
    for (int c = 0; c < NumUnlock; c++) begin
      push_key[c]     = {unlock_index_i[c*IndexWidth +: IndexWidth], unlock_way_i[c*WayWidth +: WayWidth]};
      unlock_gnt_o[c] = (fifo_cnt[c] != FcntW'(FifoDepth));
      nonempty[c]     = (fifo_cnt[c] != '0);
      push[c]         = unlock_req_i[c] & unlock_gnt_o[c];
    end
  end

  // Round-robin: first non-empty channel at or above rr_ptr, then wrap
  always_comb begin
    pop_valid = 1'b0;
    win       = '0;
    for (int i = 0; i < NumUnlock; i++) begin
      if (!pop_valid && nonempty[i] && (ChW'(i) >= rr_ptr)) begin
        pop_valid = 1'b1;
        win       = ChW'(i);
      end
    end
    for (int i = 0; i < NumUnlock; i++) begin
      if (!pop_valid && nonempty[i]) begin
        pop_valid = 1'b1;
        win       = ChW'(i);
      end
    end
    pop = '0;
    if (pop_valid) pop[win] = 1'b1;
  end

  assign pop_key    = fifo_mem[win][rd_ptr[win]];
  assign pop_way_ok = $onehot(pop_key[WayWidth-1:0]);

  always_comb begin
    hit_sat  = 1'b0;
    any_free = 1'b0;
    free_idx = '0;
    usage    = '0;
    for (int e = 0; e < NumEntries; e++) begin
      match_lock[e] = valid_q[e] && (key_q[e] == lock_key);
      match_pop[e]  = valid_q[e] && (key_q[e] == pop_key);
      if (match_lock[e] && (cnt_q[e] == '1)) hit_sat = 1'b1;
      if (!any_free && !valid_q[e]) begin
        any_free = 1'b1;
        free_idx = EntW'(e);
      end
      usage = usage + UsageW'(valid_q[e]);
    end
  end

  assign hit_lock   = |match_lock;
  assign hit_pop    = |match_pop;
  assign locked_o   = hit_lock;
  assign lock_gnt_o = lock_req_i & lock_way_ok & (hit_lock ? ~hit_sat : any_free);
  assign pop_do     = pop_valid & pop_way_ok & hit_pop;
  assign usage_o    = usage;
  assign full_o     = &valid_q;
  assign empty_o    = ~|valid_q;

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumUnlock; c++) begin
      if (push[c]) fifo_mem[c][wr_ptr[c]] <= push_key[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      for (int c = 0; c < NumUnlock; c++) begin
        rd_ptr[c]   <= '0;
        wr_ptr[c]   <= '0;
        fifo_cnt[c] <= '0;
      end
    end else begin
      if (pop_valid) rr_ptr <= (win == ChW'(NumUnlock - 1)) ? '0 : win + ChW'(1);
      for (int c = 0; c < NumUnlock; c++) begin
        if (push[c]) wr_ptr[c] <= (wr_ptr[c] == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr[c] + PtrW'(1);
        if (pop[c])  rd_ptr[c] <= (rd_ptr[c] == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr[c] + PtrW'(1);
        if (push[c] && !pop[c])      fifo_cnt[c] <= fifo_cnt[c] + FcntW'(1);
        else if (!push[c] && pop[c]) fifo_cnt[c] <= fifo_cnt[c] - FcntW'(1);
      end
    end
  end

  // Simultaneous lock and decrement of one entry cancel out
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      error_o <= 1'b0;
      for (int e = 0; e < NumEntries; e++) begin
        key_q[e] <= '0;
        cnt_q[e] <= '0;
      end
    end else begin
      if ((lock_req_i && !lock_way_ok) || (pop_valid && (!pop_way_ok || !hit_pop)))
        error_o <= 1'b1;
      for (int e = 0; e < NumEntries; e++) begin
        logic inc, dec;
        inc = lock_gnt_o && (hit_lock ? match_lock[e] : (free_idx == EntW'(e)));
        dec = pop_do && match_pop[e];
        if (inc && !dec) begin
          if (!valid_q[e]) begin
            valid_q[e] <= 1'b1;
            key_q[e]   <= lock_key;
            cnt_q[e]   <= CntWidth'(1);
          end else begin
            cnt_q[e] <= cnt_q[e] + CntWidth'(1);
          end
        end else if (dec && !inc) begin
          cnt_q[e] <= cnt_q[e] - CntWidth'(1);
          if (cnt_q[e] == CntWidth'(1)) valid_q[e] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_llc_lock_box_table.sv
// Directed self-checking bench for axi_llc_lock_box_table (three unlock channels).
module tb_axi_llc_lock_box_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lock_index = '0;
  logic [7:0]  lock_way = '0;
  logic        lock_req = 1'b0;
  logic        lock_gnt, locked;
  logic [23:0] unlock_index = '0;
  logic [23:0] unlock_way = '0;
  logic [2:0]  unlock_req = '0;
  logic [2:0]  unlock_gnt;
  logic [3:0]  usage;
  logic        full, empty, error;

  int checks = 0;
  int errors = 0;

  axi_llc_lock_box_table #(
    .IndexWidth(8), .WayWidth(8), .NumEntries(8), .CntWidth(3),
    .NumUnlock(3), .FifoDepth(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .lock_index_i(lock_index), .lock_way_i(lock_way), .lock_req_i(lock_req),
    .lock_gnt_o(lock_gnt), .locked_o(locked),
    .unlock_index_i(unlock_index), .unlock_way_i(unlock_way), .unlock_req_i(unlock_req),
    .unlock_gnt_o(unlock_gnt), .usage_o(usage), .full_o(full), .empty_o(empty),
    .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lock(input logic [7:0] idx, input logic [7:0] way, input logic req);
    lock_index = idx;
    lock_way   = way;
    lock_req   = req;
    #1;
  endtask

  task automatic set_unl(input int ch, input logic [7:0] idx, input logic [7:0] way, input logic req);
    unlock_index[ch*8 +: 8] = idx;
    unlock_way[ch*8 +: 8]   = way;
    unlock_req[ch]          = req;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_gnt", 32'(lock_gnt), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_unlock_gnt", 32'(unlock_gnt), 32'h7);
    chk("rst_usage", 32'(usage), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    tick();

    // Single lock, exact-match lookup
    set_lock(8'h12, 8'h04, 1'b1);
    chk("lock1_gnt", 32'(lock_gnt), 32'd1);
    tick();
    set_lock(8'h12, 8'h04, 1'b0);
    chk("lock1_locked", 32'(locked), 32'd1);
    chk("lock1_usage", 32'(usage), 32'd1);
    chk("lock1_empty", 32'(empty), 32'd0);
    set_lock(8'h12, 8'h08, 1'b0);
    chk("lock1_other_way", 32'(locked), 32'd0);

    // Saturate one counter at 7
    for (int i = 0; i < 7; i++) begin
      set_lock(8'h20, 8'h01, 1'b1);
      chk("sat_gnt", 32'(lock_gnt), 32'd1);
      tick();
    end
    set_lock(8'h20, 8'h01, 1'b1);
    chk("sat_8th_gnt", 32'(lock_gnt), 32'd0);
    tick();
    set_lock(8'h20, 8'h01, 1'b0);
    chk("sat_no_error", 32'(error), 32'd0);
    chk("sat_usage", 32'(usage), 32'd2);

    // Seven unlocks on channel 1, one per cycle
    set_unl(1, 8'h20, 8'h01, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("unl_ch1_gnt", 32'(unlock_gnt[1]), 32'd1);
      tick();
    end
    set_unl(1, 8'h20, 8'h01, 1'b0);
    #1;
    chk("unl_t1_locked", 32'(locked), 32'd1);
    tick();
    chk("unl_t2_locked", 32'(locked), 32'd0);
    chk("unl_t2_usage", 32'(usage), 32'd1);

    // Fill the table
    for (int i = 0; i < 7; i++) begin
      set_lock(8'(8'h30 + i), 8'h01, 1'b1);
      tick();
    end
    set_lock(8'h40, 8'h02, 1'b0);
    chk("full_full", 32'(full), 32'd1);
    chk("full_usage", 32'(usage), 32'd8);
    set_lock(8'h40, 8'h02, 1'b1);
    chk("full_new_gnt", 32'(lock_gnt), 32'd0);
    set_lock(8'h12, 8'h04, 1'b1);
    chk("full_hit_gnt", 32'(lock_gnt), 32'd1);
    set_lock(8'h12, 8'h04, 1'b0);

    // Reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_usage", 32'(usage), 32'd0);
    chk("rst2_locked", 32'(locked), 32'd0);

    // One unlock per channel in one cycle: pops 0,1,2
    for (int i = 0; i < 3; i++) begin
      set_lock(8'(8'h30 + i), 8'h01, 1'b1);
      tick();
    end
    set_lock(8'h30, 8'h01, 1'b0);
    for (int c = 0; c < 3; c++) set_unl(c, 8'(8'h30 + c), 8'h01, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) set_unl(c, 8'h00, 8'h00, 1'b0);
    #1;
    chk("rr_push_gnt", 32'(unlock_gnt), 32'h7);
    tick();
    set_lock(8'h30, 8'h01, 1'b0);
    chk("rr_pop0_k0", 32'(locked), 32'd0);
    set_lock(8'h31, 8'h01, 1'b0);
    chk("rr_pop0_k1", 32'(locked), 32'd1);
    chk("rr_pop0_gnt", 32'(unlock_gnt), 32'h7);
    tick();
    chk("rr_pop1_k1", 32'(locked), 32'd0);
    set_lock(8'h32, 8'h01, 1'b0);
    chk("rr_pop1_k2", 32'(locked), 32'd1);
    chk("rr_pop1_usage", 32'(usage), 32'd1);
    tick();
    chk("rr_pop2_k2", 32'(locked), 32'd0);
    chk("rr_pop2_empty", 32'(empty), 32'd1);
    chk("rr_error", 32'(error), 32'd0);

    // Lock and decrement on the same entry in the same cycle
    set_lock(8'h50, 8'h10, 1'b1);
    tick();
    set_lock(8'h50, 8'h10, 1'b0);
    set_unl(0, 8'h50, 8'h10, 1'b1);
    tick();
    set_unl(0, 8'h50, 8'h10, 1'b0);
    set_lock(8'h50, 8'h10, 1'b1);
    chk("same_gnt", 32'(lock_gnt), 32'd1);
    tick();
    set_lock(8'h50, 8'h10, 1'b0);
    chk("same_locked", 32'(locked), 32'd1);
    chk("same_usage", 32'(usage), 32'd1);
    set_unl(0, 8'h50, 8'h10, 1'b1);
    tick();
    set_unl(0, 8'h50, 8'h10, 1'b0);
    tick();
    #1;
    chk("same_count1_locked", 32'(locked), 32'd0);
    chk("same_error", 32'(error), 32'd0);

    // Unlock of a never-locked key
    set_unl(2, 8'h77, 8'h01, 1'b1);
    tick();
    set_unl(2, 8'h00, 8'h00, 1'b0);
    #1;
    chk("err_t1", 32'(error), 32'd0);
    tick();
    chk("err_t2", 32'(error), 32'd1);
    tick(); tick();
    chk("err_sticky", 32'(error), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("err_rst_clear", 32'(error), 32'd0);

    // Non-one-hot way on a lock
    set_lock(8'h12, 8'h06, 1'b1);
    chk("bad_way_gnt", 32'(lock_gnt), 32'd0);
    tick();
    set_lock(8'h12, 8'h06, 1'b0);
    chk("bad_way_error", 32'(error), 32'd1);
    chk("bad_way_usage", 32'(usage), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
